// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state encodings, opcodes and datapath select codes
// for the multicycle MIPS controller. MC_CTRL_JAL_EN enables jal decode.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC_R = 4'd6,
        ST_EXEC_I = 4'd7,
        ST_RWB    = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JUMP   = 4'd10,
        ST_JAL    = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] ALUOP_ADD = 2'd0;
    localparam logic [1:0] ALUOP_SUB = 2'd1;
    localparam logic [1:0] ALUOP_OR  = 2'd2;

    localparam logic       SRCA_PC  = 1'b0;
    localparam logic       SRCA_REG = 1'b1;

    localparam logic [1:0] SRCB_REG  = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_EXT  = 2'd2;
    localparam logic [1:0] SRCB_SHL2 = 2'd3;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MDR = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;

    // DECODE successor; FETCH means the instruction is not supported
    function automatic state_e decode_next(input logic [5:0] op,
                                           input logic [5:0] funct);
        state_e nxt;
        nxt = ST_FETCH;
        case (op)
            OP_RTYPE: begin
                if (funct == FN_ADDU || funct == FN_SUBU)
                    nxt = ST_EXEC_R;
            end
            OP_ORI, OP_LUI: nxt = ST_EXEC_I;
            OP_LW, OP_SW:   nxt = ST_MEMADR;
            OP_BEQ:         nxt = ST_BRANCH;
            OP_J:           nxt = ST_JUMP;
`ifdef MC_CTRL_JAL_EN
            OP_JAL:         nxt = ST_JAL;
`endif
            default:        nxt = ST_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_ctrl_wait.sv
// mc_ctrl_wait: counts consecutive not-ready cycles in a memory wait
// state; flags expiry on the MAX-th one and holds a sticky timeout.
module mc_ctrl_wait
    import mc_ctrl_pkg::*;
#(
    parameter int MAX = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic wait_i,
    input  logic ready_i,
    output logic expire_o,
    output logic timeout_o
);

    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;

    // counter restarts whenever the wait ends (ready, expiry or leaving)
    always_comb begin
        expire_o = wait_i & ~ready_i & (cnt_q == CW'(MAX - 1));
        cnt_d    = '0;
        if (wait_i && !ready_i && !expire_o)
            cnt_d = cnt_q + CW'(1);
        tmo_d = tmo_q | expire_o;
    end

    // counter and sticky timeout registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout_o = tmo_q;

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS control FSM driving the shared ALU, PC, IR,
// register file and data memory. Define MC_CTRL_JAL_EN to add jal.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ST_W         = 4,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      op,
    input  logic [5:0]      funct,
    input  logic            zero,
    input  logic            mem_ready,
    output logic [1:0]      alu_op,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      ext_op,
    output logic            pc_wr,
    output logic [1:0]      pc_src,
    output logic            ir_wr,
    output logic            mem_wr,
    output logic            reg_wr,
    output logic [1:0]      reg_dst,
    output logic [1:0]      mem_to_reg,
    output logic            instr_done,
    output logic            timeout,
    output logic [ST_W-1:0] state
);

    state_e state_q, state_d;
    logic   waiting, expire;
    logic   pc_wr_c, ir_wr_c, mem_wr_c, reg_wr_c, done_c;

    assign waiting = (state_q == ST_FETCH) ||
                     (state_q == ST_MEMRD) ||
                     (state_q == ST_MEMWR);

    mc_ctrl_wait #(.MAX(MEM_WAIT_MAX)) u_wait (
        .clk_i    (clk),
        .rst_i    (reset),
        .wait_i   (waiting),
        .ready_i  (mem_ready),
        .expire_o (expire),
        .timeout_o(timeout)
    );

    // next state and datapath controls from state, opcode and zero flag
    always_comb begin
        state_d    = state_q;
        alu_op     = ALUOP_ADD;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REG;
        ext_op     = EXT_ZERO;
        pc_src     = PCSRC_ALU;
        reg_dst    = DST_RT;
        mem_to_reg = M2R_ALU;
        pc_wr_c    = 1'b0;
        ir_wr_c    = 1'b0;
        mem_wr_c   = 1'b0;
        reg_wr_c   = 1'b0;
        done_c     = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    alu_src_b = SRCB_FOUR;
                    pc_wr_c   = 1'b1;
                    ir_wr_c   = 1'b1;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_src_b = SRCB_SHL2;
                ext_op    = EXT_SIGN;
                state_d   = decode_next(op, funct);
                done_c    = (state_d == ST_FETCH);
            end
            ST_MEMADR: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_EXT;
                ext_op    = EXT_SIGN;
                state_d   = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                if (mem_ready)
                    state_d = ST_MEMWB;
                else if (expire)
                    state_d = ST_FETCH;
            end
            ST_MEMWB: begin
                reg_wr_c   = 1'b1;
                mem_to_reg = M2R_MDR;
                done_c     = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEMWR: begin
                if (mem_ready) begin
                    mem_wr_c = 1'b1;
                    done_c   = 1'b1;
                    state_d  = ST_FETCH;
                end else if (expire) begin
                    state_d = ST_FETCH;
                end else begin
                    mem_wr_c = 1'b1;
                end
            end
            ST_EXEC_R: begin
                alu_src_a = SRCA_REG;
                alu_op    = (funct == FN_SUBU) ? ALUOP_SUB : ALUOP_ADD;
                state_d   = ST_RWB;
            end
            ST_EXEC_I: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_EXT;
                alu_op    = ALUOP_OR;
                ext_op    = (op == OP_LUI) ? EXT_LUI : EXT_ZERO;
                state_d   = ST_RWB;
            end
            ST_RWB: begin
                reg_wr_c = 1'b1;
                reg_dst  = (op == OP_RTYPE) ? DST_RD : DST_RT;
                done_c   = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a = SRCA_REG;
                alu_op    = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_wr_c   = zero;
                done_c    = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_JUMP: begin
                pc_src  = PCSRC_JUMP;
                pc_wr_c = 1'b1;
                done_c  = 1'b1;
                state_d = ST_FETCH;
            end
`ifdef MC_CTRL_JAL_EN
            ST_JAL: begin
                pc_src     = PCSRC_JUMP;
                pc_wr_c    = 1'b1;
                reg_wr_c   = 1'b1;
                reg_dst    = DST_RA;
                mem_to_reg = M2R_PC;
                done_c     = 1'b1;
                state_d    = ST_FETCH;
            end
`endif
            default: state_d = ST_FETCH;
        endcase
    end

    // state register; reset abandons any instruction in flight
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_FETCH;
        else
            state_q <= state_d;
    end

    assign pc_wr      = pc_wr_c  & ~reset;
    assign ir_wr      = ir_wr_c  & ~reset;
    assign mem_wr     = mem_wr_c & ~reset;
    assign reg_wr     = reg_wr_c & ~reset;
    assign instr_done = done_c   & ~reset;
    assign state      = ST_W'(state_q);

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: random instruction stream against a per-instruction step
// script model; covers waits, timeouts, branches, illegal ops and reset.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [5:0] op, funct;
    logic [1:0] alu_op, alu_src_b, ext_op, pc_src, reg_dst, mem_to_reg;
    logic       alu_src_a, pc_wr, ir_wr, mem_wr, reg_wr, instr_done;
    logic       timeout;
    logic [3:0] state;

    mc_ctrl #(.ST_W(4), .MEM_WAIT_MAX(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .alu_op    (alu_op),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .ext_op    (ext_op),
        .pc_wr     (pc_wr),
        .pc_src    (pc_src),
        .ir_wr     (ir_wr),
        .mem_wr    (mem_wr),
        .reg_wr    (reg_wr),
        .reg_dst   (reg_dst),
        .mem_to_reg(mem_to_reg),
        .instr_done(instr_done),
        .timeout   (timeout),
        .state     (state)
    );

    always #5 clk = ~clk;

`ifdef MC_CTRL_JAL_EN
    localparam bit JAL = 1'b1;
`else
    localparam bit JAL = 1'b0;
`endif

    // enable bits of the packed output vector: pc_wr ir_wr mem_wr reg_wr done
    localparam logic [17:0] EN = 18'b00_0_00_00_1_00_1_1_1_00_00_1;
    localparam int WAIT_MAX = 15;

    typedef struct {
        int          st;
        bit          wt;
        bit          br;
        logic [17:0] rdy;
        logic [17:0] wai;
    } step_t;

    step_t       q[$];
    int          total = 0;
    int          bad = 0;
    int          wcnt, stuck;
    bit          tmo_m, rst_c;
    logic [17:0] e;
    logic [17:0] obs;

    assign obs = {alu_op, alu_src_a, alu_src_b, ext_op, pc_wr, pc_src,
                  ir_wr, mem_wr, reg_wr, reg_dst, mem_to_reg, instr_done};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] ov(int alu, int sa, int sb, int ext,
                                       int pcw, int pcs, int irw, int mw,
                                       int rw, int rd, int m2r, int dn);
        logic [17:0] v;
        v = {alu[1:0], sa[0], sb[1:0], ext[1:0], pcw[0], pcs[1:0],
             irw[0], mw[0], rw[0], rd[1:0], m2r[1:0], dn[0]};
        return v;
    endfunction

    function automatic step_t mk(int st, logic [17:0] r, bit wt,
                                 logic [17:0] w, bit br);
        step_t x;
        x.st  = st;
        x.rdy = r;
        x.wt  = wt;
        x.wai = w;
        x.br  = br;
        return x;
    endfunction

    function automatic bit legal(logic [5:0] o_, logic [5:0] f_);
        if (o_ == 6'h00)
            return (f_ == 6'h21) || (f_ == 6'h23);
        return (o_ == 6'h0D) || (o_ == 6'h0F) || (o_ == 6'h23) ||
               (o_ == 6'h2B) || (o_ == 6'h04) || (o_ == 6'h02) ||
               (JAL && o_ == 6'h03);
    endfunction

    // pick a new instruction and script the cycles it should take
    task automatic new_instr();
        int          k;
        logic [5:0]  po, pf;
        logic [17:0] z;
        z  = '0;
        k  = $urandom_range(0, 9);
        po = 6'($urandom_range(0, 63));
        pf = 6'($urandom_range(0, 63));
        case (k)
            0: begin po = 6'h00; pf = 6'h21; end
            1: begin po = 6'h00; pf = 6'h23; end
            2: po = 6'h0D;
            3: po = 6'h0F;
            4: po = 6'h23;
            5: po = 6'h2B;
            6: po = 6'h04;
            7: po = 6'h02;
            8: po = 6'h03;
            default: begin
                while (legal(po, pf)) begin
                    po = 6'($urandom_range(0, 63));
                    pf = 6'($urandom_range(0, 63));
                end
            end
        endcase
        op    = po;
        funct = pf;
        k     = $urandom_range(0, 15);
        stuck = (k == 0) ? 2 : (k < 4) ? 1 : 0;
        q.push_back(mk(0, ov(0,0,1,0,1,0,1,0,0,0,0,0), 1, z, 0));
        if (!legal(po, pf)) begin
            q.push_back(mk(1, ov(0,0,3,1,0,0,0,0,0,0,0,1), 0, z, 0));
        end else begin
            q.push_back(mk(1, ov(0,0,3,1,0,0,0,0,0,0,0,0), 0, z, 0));
            if (po == 6'h00) begin
                q.push_back(mk(6, ov((pf == 6'h23) ? 1 : 0,1,0,0,
                                     0,0,0,0,0,0,0,0), 0, z, 0));
                q.push_back(mk(8, ov(0,0,0,0,0,0,0,0,1,1,0,1), 0, z, 0));
            end else if (po == 6'h0D || po == 6'h0F) begin
                q.push_back(mk(7, ov(2,1,2,(po == 6'h0F) ? 2 : 0,
                                     0,0,0,0,0,0,0,0), 0, z, 0));
                q.push_back(mk(8, ov(0,0,0,0,0,0,0,0,1,0,0,1), 0, z, 0));
            end else if (po == 6'h23) begin
                q.push_back(mk(2, ov(0,1,2,1,0,0,0,0,0,0,0,0), 0, z, 0));
                q.push_back(mk(3, z, 1, z, 0));
                q.push_back(mk(4, ov(0,0,0,0,0,0,0,0,1,0,1,1), 0, z, 0));
            end else if (po == 6'h2B) begin
                q.push_back(mk(2, ov(0,1,2,1,0,0,0,0,0,0,0,0), 0, z, 0));
                q.push_back(mk(5, ov(0,0,0,0,0,0,0,1,0,0,0,1), 1,
                               ov(0,0,0,0,0,0,0,1,0,0,0,0), 0));
            end else if (po == 6'h04) begin
                q.push_back(mk(9, ov(1,1,0,0,0,1,0,0,0,0,0,1), 0, z, 1));
            end else if (po == 6'h02) begin
                q.push_back(mk(10, ov(0,0,0,0,1,2,0,0,0,0,0,1), 0, z, 0));
            end else begin
                q.push_back(mk(11, ov(0,0,0,0,1,2,0,0,1,2,2,1), 0, z, 0));
            end
        end
    endtask

    initial begin
        step_t s;
        reset     = 1'b1;
        mem_ready = 1'b1;
        zero      = 1'b1;
        op        = 6'h00;
        funct     = 6'h21;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_tmo", 32'(timeout), 32'd0);
        check("rst_en", 32'(obs & EN), 32'd0);
        tmo_m = 1'b0;
        wcnt  = 0;
        stuck = 0;
        q.delete();
        for (int c = 0; c < 6000; c++) begin
            if (q.size() == 0)
                new_instr();
            s         = q[0];
            rst_c     = ($urandom_range(0, 99) == 0);
            reset     = rst_c;
            zero      = 1'($urandom_range(0, 1));
            mem_ready = (stuck == 2 || (stuck == 1 && s.st != 0)) ? 1'b0 :
                        ($urandom_range(0, 3) != 0);
            #1;
            check($sformatf("state@%0d", c), 32'(state), 32'(s.st));
            check($sformatf("timeout@%0d", c), 32'(timeout), 32'(tmo_m));
            if (rst_c) begin
                check($sformatf("rst_en st%0d", s.st),
                      32'(obs & EN), 32'd0);
                q.delete();
                wcnt  = 0;
                tmo_m = 1'b0;
            end else if (s.wt && !mem_ready) begin
                wcnt++;
                if (wcnt == WAIT_MAX) begin
                    check($sformatf("expire st%0d", s.st), 32'(obs), 32'd0);
                    tmo_m = 1'b1;
                    wcnt  = 0;
                    q.delete();
                end else begin
                    check($sformatf("wait st%0d", s.st), 32'(obs),
                          32'(s.wai));
                end
            end else begin
                e = s.rdy;
                if (s.br)
                    e[10] = zero;
                check($sformatf("step st%0d op%h", s.st, op), 32'(obs),
                      32'(e));
                void'(q.pop_front());
                wcnt = 0;
            end
            @(posedge clk);
            #1;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
